// File: rtl/pair_judge.sv
// Two-player memory-game referee: accepts two revealed tiles, holds them visible
// for SHOW_CYCLES cycles, then pulses match or par and updates turn and scores.
module pair_judge #(
  parameter int SHOW_CYCLES = 8,
  parameter int NUM_PAIRS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       select,
  input  logic [3:0] sel_index,
  input  logic [3:0] sel_label,
  output logic       par,
  output logic       match,
  output logic [3:0] first_idx,
  output logic [3:0] second_idx,
  output logic       player,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       busy,
  output logic       game_over
);

  typedef enum logic [2:0] {
    WAIT_FIRST,
    WAIT_SECOND,
    SHOW,
    VERDICT,
    DONE
  } state_t;

  localparam int             CW   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'((SHOW_CYCLES > 0) ? SHOW_CYCLES - 1 : 0);
  localparam logic [4:0]     NP   = 5'(NUM_PAIRS);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [3:0]    first_label, second_label;
  logic          label_ok, take_first, take_second, in_verdict, same;
  logic [3:0]    score0_next, score1_next;
  logic [4:0]    sum_next;

  // Verdict pulses are decoded from the state, so they can never leak outside VERDICT.
  always_comb begin
    label_ok   = select && (sel_label != 4'h0) && (sel_label != 4'hF);
    in_verdict = (state == VERDICT);
    same       = (first_label == second_label);
    match      = in_verdict && same;
    par        = in_verdict && !same;
    busy       = (state == SHOW) || in_verdict;
    game_over  = (state == DONE);
  end

  always_comb begin
    score0_next = score0;
    score1_next = score1;
    if (match && !player && (score0 != 4'hF)) score0_next = score0 + 4'd1;
    if (match &&  player && (score1 != 4'hF)) score1_next = score1 + 4'd1;
    sum_next = {1'b0, score0_next} + {1'b0, score1_next};
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    take_first  = 1'b0;
    take_second = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (label_ok) begin
          take_first = 1'b1;
          state_next = WAIT_SECOND;
        end
      end
      WAIT_SECOND: begin
        if (label_ok && (sel_index != first_idx)) begin
          take_second = 1'b1;
          state_next  = (SHOW_CYCLES == 0) ? VERDICT : SHOW;
        end
      end
      SHOW:    if (cnt == LAST) state_next = VERDICT;
      VERDICT: state_next = (sum_next == NP) ? DONE : WAIT_FIRST;
      DONE:    state_next = DONE;
      default: state_next = WAIT_FIRST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_FIRST;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_idx    <= 4'd0;
      second_idx   <= 4'd0;
      first_label  <= 4'd0;
      second_label <= 4'd0;
      cnt          <= '0;
      player       <= 1'b0;
      score0       <= 4'd0;
      score1       <= 4'd0;
    end else begin
      if (take_first) begin
        first_idx   <= sel_index;
        first_label <= sel_label;
      end
      if (take_second) begin
        second_idx   <= sel_index;
        second_label <= sel_label;
        cnt          <= '0;
      end else if (state == SHOW) begin
        cnt <= cnt + 1'b1;
      end
      if (in_verdict) begin
        score0 <= score0_next;
        score1 <= score1_next;
        if (par) player <= ~player;
      end
    end
  end

endmodule

// File: tb/tb_pair_judge.sv
// Directed bench for pair_judge: three instances (normal, short game, zero delay)
// share one stimulus stream; each test resets and watches the relevant instance.
module tb_pair_judge;

  logic       clk = 1'b0;
  logic       rst, select;
  logic [3:0] sel_index, sel_label;

  logic       a_par, a_match, a_player, a_busy, a_go;
  logic [3:0] a_first, a_second, a_s0, a_s1;
  logic       b_par, b_match, b_player, b_busy, b_go;
  logic [3:0] b_first, b_second, b_s0, b_s1;
  logic       c_par, c_match, c_player, c_busy, c_go;
  logic [3:0] c_first, c_second, c_s0, c_s1;

  pair_judge #(.SHOW_CYCLES(8), .NUM_PAIRS(8)) dut_a (
    .clk(clk), .rst(rst), .select(select), .sel_index(sel_index), .sel_label(sel_label),
    .par(a_par), .match(a_match), .first_idx(a_first), .second_idx(a_second),
    .player(a_player), .score0(a_s0), .score1(a_s1), .busy(a_busy), .game_over(a_go));

  pair_judge #(.SHOW_CYCLES(2), .NUM_PAIRS(2)) dut_b (
    .clk(clk), .rst(rst), .select(select), .sel_index(sel_index), .sel_label(sel_label),
    .par(b_par), .match(b_match), .first_idx(b_first), .second_idx(b_second),
    .player(b_player), .score0(b_s0), .score1(b_s1), .busy(b_busy), .game_over(b_go));

  pair_judge #(.SHOW_CYCLES(0), .NUM_PAIRS(16)) dut_c (
    .clk(clk), .rst(rst), .select(select), .sel_index(sel_index), .sel_label(sel_label),
    .par(c_par), .match(c_match), .first_idx(c_first), .second_idx(c_second),
    .player(c_player), .score0(c_s0), .score1(c_s1), .busy(c_busy), .game_over(c_go));

  always #5 clk = ~clk;

  int   passed = 0;
  int   total  = 0;
  int   watch  = 0;
  logic w_match, w_par;

  always_comb begin
    w_match = a_match;
    w_par   = a_par;
    case (watch)
      1: begin w_match = b_match; w_par = b_par; end
      2: begin w_match = c_match; w_par = c_par; end
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0] i1, l1, i2, l2;
    logic       exp_match;
    logic       exp_player;
    logic [3:0] exp_s0, exp_s1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Presents a one-cycle select; returns at the negedge just after it was sampled.
  task automatic pulse_select(input logic [3:0] idx, input logic [3:0] lbl);
    @(negedge clk);
    select    = 1'b1;
    sel_index = idx;
    sel_label = lbl;
    @(negedge clk);
    select    = 1'b0;
  endtask

  // Counts negedges until the watched verdict pulse; 0 means the cycle right after the sampling edge.
  task automatic wait_verdict(output int k, output logic m, output logic p);
    k = 0;
    while (!(w_match || w_par) && k < 40) begin
      @(negedge clk);
      k++;
    end
    m = w_match;
    p = w_par;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    select = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    int   k;
    logic m, p, seen;

    rst = 1'b1; select = 1'b0; sel_index = 4'd0; sel_label = 4'd0;
    vecs[0] = '{4'd2, 4'd5,  4'd9,  4'd5,  1'b1, 1'b0, 4'd1, 4'd0};
    vecs[1] = '{4'd1, 4'd3,  4'd4,  4'd6,  1'b0, 1'b1, 4'd1, 4'd0};
    vecs[2] = '{4'd0, 4'd7,  4'd15, 4'd7,  1'b1, 1'b1, 4'd1, 4'd1};
    vecs[3] = '{4'd3, 4'd1,  4'd5,  4'd14, 1'b0, 1'b0, 4'd1, 4'd1};
    vecs[4] = '{4'd6, 4'd14, 4'd7,  4'd14, 1'b1, 1'b0, 4'd2, 4'd1};

    do_reset();
    check("reset_outputs", {11'd0, a_par, a_match, a_first, a_second, a_player,
                            a_s0, a_s1, a_busy, a_go}, 32'd0);

    // Table: verdict lands on the 8th edge after the sampling edge (cycle SHOW_CYCLES+1).
    watch = 0;
    foreach (vecs[i]) begin
      pulse_select(vecs[i].i1, vecs[i].l1);
      pulse_select(vecs[i].i2, vecs[i].l2);
      check($sformatf("busy_show[%0d]", i), a_busy, 1);
      wait_verdict(k, m, p);
      check($sformatf("latency[%0d]", i), k, 8);
      check($sformatf("match[%0d]", i), m, vecs[i].exp_match);
      check($sformatf("par[%0d]", i), p, !vecs[i].exp_match);
      check($sformatf("first_idx[%0d]", i), a_first, vecs[i].i1);
      check($sformatf("second_idx[%0d]", i), a_second, vecs[i].i2);
      @(negedge clk);
      check($sformatf("player[%0d]", i), a_player, vecs[i].exp_player);
      check($sformatf("score0[%0d]", i), a_s0, vecs[i].exp_s0);
      check($sformatf("score1[%0d]", i), a_s1, vecs[i].exp_s1);
      check($sformatf("pulse_end[%0d]", i), {a_match, a_par, a_busy}, 0);
    end

    // Ignored selects: same index, reserved label, and a select during busy.
    do_reset();
    pulse_select(4'd7, 4'd2);
    pulse_select(4'd7, 4'd3);
    check("same_idx_ignored", a_busy, 0);
    pulse_select(4'd10, 4'hF);
    check("cursor_label_ignored", a_busy, 0);
    pulse_select(4'd8, 4'd2);
    check("second_accepted", {a_busy, a_first, a_second}, {1'b1, 4'd7, 4'd8});
    pulse_select(4'd11, 4'd4);
    wait_verdict(k, m, p);
    check("busy_select_latency", k, 6);
    check("busy_select_match", m, 1);
    @(negedge clk);
    check("busy_select_dropped", a_first, 7);
    pulse_select(4'd12, 4'd9);
    check("fresh_pair_first", a_first, 12);

    // Reset mid-SHOW, with a select in the reset cycle that must be discarded.
    do_reset();
    pulse_select(4'd3, 4'd6);
    pulse_select(4'd5, 4'd6);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; select = 1'b1; sel_index = 4'd9; sel_label = 4'd4;
    @(negedge clk);
    rst = 1'b0; select = 1'b0;
    check("reset_mid_show", {11'd0, a_par, a_match, a_first, a_second, a_player,
                             a_s0, a_s1, a_busy, a_go}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | a_match | a_par;
    end
    check("no_verdict_after_reset", seen, 0);

    // End of game on the two-pair instance.
    do_reset();
    watch = 1;
    pulse_select(4'd0, 4'd5);
    pulse_select(4'd1, 4'd5);
    wait_verdict(k, m, p);
    check("short_latency", k, 2);
    @(negedge clk);
    check("not_over_yet", b_go, 0);
    pulse_select(4'd2, 4'd6);
    pulse_select(4'd3, 4'd6);
    wait_verdict(k, m, p);
    check("second_match", m, 1);
    @(negedge clk);
    check("game_over", {b_go, b_s0, b_busy}, {1'b1, 4'd2, 1'b0});
    pulse_select(4'd4, 4'd7);
    pulse_select(4'd5, 4'd7);
    repeat (6) @(negedge clk);
    check("done_terminal", {b_go, b_first, b_s0, b_busy}, {1'b1, 4'd2, 4'd2, 1'b0});

    // Zero show time and score saturation.
    do_reset();
    watch = 2;
    pulse_select(4'd0, 4'd5);
    pulse_select(4'd1, 4'd5);
    wait_verdict(k, m, p);
    check("zero_delay_latency", k, 0);
    check("zero_delay_match", m, 1);
    for (int i = 0; i < 15; i++) begin
      pulse_select(4'd0, 4'd5);
      pulse_select(4'd1, 4'd5);
      @(negedge clk);
    end
    check("score_saturates", {c_s0, c_s1, c_player, c_go}, {4'hF, 4'd0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pair_judge.md
PAIR_JUDGE -- requirements
Module: pair_judge

Interface
REQ-001 The block SHALL have parameter SHOW_CYCLES, default 8, meaning the number of clk cycles both revealed tiles stay visible before the verdict is applied.
REQ-002 The block SHALL have parameter NUM_PAIRS, default 8, meaning the number of matched pairs that ends the game.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 select  input  1  one-cycle pulse meaning a tile has just been revealed.
REQ-006 sel_index  input  4  board position (0..15) of the revealed tile; valid with select.
REQ-007 sel_label  input  4  label of the revealed tile; valid with select.
REQ-008 par  output  1  one-cycle pulse meaning the tiles at first_idx and second_idx are returned to hidden (mismatch).
REQ-009 match  output  1  one-cycle pulse meaning the tiles at first_idx and second_idx are a pair and stay revealed.
REQ-010 first_idx, second_idx  output  4 each  positions of the current first and second selections.
REQ-011 player  output  1  player whose turn it is (0 or 1).
REQ-012 score0, score1  output  4 each  pairs won by player 0 and player 1.
REQ-013 busy  output  1  high from the second accepted select until the verdict pulse, inclusive; selects are ignored while it is high.
REQ-014 game_over  output  1  level; high once the sum of score0 and score1 equals NUM_PAIRS.

Function
REQ-015 The block SHALL implement the states WAIT_FIRST, WAIT_SECOND, SHOW, VERDICT, and DONE.
REQ-016 In WAIT_FIRST, a select with a valid label SHALL latch sel_index into first_idx and sel_label internally, then move to WAIT_SECOND.
REQ-017 A label SHALL be valid unless it is 4'b0000 or 4'b1111, which are reserved as the hidden code and the cursor code.
REQ-018 A select with an invalid label SHALL be ignored in every state.
REQ-019 In WAIT_SECOND, a select with a valid label and sel_index not equal to first_idx SHALL latch second_idx, clear the SHOW counter, and move to SHOW.
REQ-020 In WAIT_SECOND, a select with sel_index equal to first_idx SHALL be ignored, and the state SHALL NOT change.
REQ-021 SHOW SHALL last exactly SHOW_CYCLES cycles, then move to VERDICT.
REQ-022 With SHOW_CYCLES=0, the block SHALL go straight from the accepting edge to VERDICT on the next cycle.
REQ-023 VERDICT SHALL last one cycle.
REQ-024 In VERDICT with equal labels, the block SHALL assert match, increment the score of the current player, and keep player unchanged.
REQ-025 In VERDICT with unequal labels, the block SHALL assert par and toggle player.
REQ-026 After VERDICT, the block SHALL move to DONE if the updated score sum equals NUM_PAIRS, and to WAIT_FIRST otherwise.
REQ-027 The verdict pulse SHALL occur exactly SHOW_CYCLES+1 cycles after the cycle in which the second select is sampled.
REQ-028 first_idx and second_idx SHALL hold their values through VERDICT and until the next accepted select overwrites them.
REQ-029 In SHOW, VERDICT, and DONE, select SHALL be ignored; busy SHALL be high in SHOW and VERDICT only.
REQ-030 The score counters SHALL saturate at 4'hF and never wrap.
REQ-031 match and par SHALL be mutually exclusive and never high outside VERDICT.
REQ-032 DONE SHALL be terminal until reset; game_over SHALL be high in DONE.

Reset
REQ-033 When rst is high at a clock edge, the block SHALL enter WAIT_FIRST regardless of current state, including mid-SHOW and mid-VERDICT.
REQ-034 On reset, the block SHALL set player=0, score0=0, score1=0, first_idx=0, second_idx=0, par=0, match=0, busy=0, game_over=0, and the SHOW counter to 0.
REQ-035 A select sampled in the same cycle as rst SHALL be discarded.

Verification
REQ-036 Match case: SHOW_CYCLES=8; select (idx 2, label 5), then select (idx 9, label 5) -> match pulses exactly 9 cycles after the second select; score0=1; player=0; first_idx=2; second_idx=9.
REQ-037 Mismatch case: select (idx 1, label 3), then select (idx 4, label 6) -> par pulses once; match=0; player becomes 1; scores unchanged.
REQ-038 Ignored selects: select idx 7 twice, then a select with label 4'b1111, then idx 8 -> only idx 8 is accepted as second; selects during busy are dropped, and the next pair starts fresh after the verdict.
REQ-039 End of game: NUM_PAIRS=2; two matching pairs by player 0 -> game_over rises in the cycle after the second match; later selects are ignored.
REQ-040 Reset mid-SHOW: assert rst for one cycle during SHOW -> no par or match pulse occurs, and every output equals its REQ-034 value on the next cycle.
REQ-041 Zero delay and saturation: SHOW_CYCLES=0 -> verdict arrives 1 cycle after the second select; forcing 16 matches with NUM_PAIRS=16 -> score0 holds at 4'hF.
